vram_write_queue: RTL and testbench

VRAM_WRITE_QUEUE -- requirements
Module: vram_write_queue

---
 rtl/vram_write_queue_pkg.sv | 26 ++
 rtl/vram_write_queue_fifo.sv | 53 +++++
 rtl/vram_write_queue.sv | 147 ++++++++++++++
 tb/tb_vram_write_queue.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_write_queue_pkg.sv
// Shared types and default address map for the VRAM write queue.
package vram_write_queue_pkg;

    localparam logic [15:0] PF_BASE_DEF  = 16'h0400;
    localparam logic [15:0] MOB_BASE_DEF = 16'h07C0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GUARD = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef enum logic {
        TGT_PF  = 1'b0,
        TGT_MOB = 1'b1
    } target_t;

    typedef struct packed {
        target_t     target;
        logic [9:0]  offset;
        logic [7:0]  data;
    } wq_entry_t;

    localparam int ENTRY_W = $bits(wq_entry_t);

endpackage

// File: rtl/vram_write_queue_fifo.sv
// Synchronous FIFO, power-of-two depth, combinational head output.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_l,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push, do_pop;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/vram_write_queue.sv
// Buffers CPU VRAM writes and replays them to playfield / motion-object RAM
// only during vertical blanking.
module vram_write_queue
    import vram_write_queue_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] PF_BASE    = PF_BASE_DEF,
    parameter logic [15:0] MOB_BASE   = MOB_BASE_DEF
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        wr_valid,
    input  logic [15:0] wr_addr,
    input  logic [7:0]  wr_data,
    output logic        wr_ready,
    input  logic        vblank,
    output logic [9:0]  pf_addr,
    output logic [7:0]  pf_data,
    output logic        pf_we_l,
    output logic [5:0]  mob_addr,
    output logic [7:0]  mob_data,
    output logic        mob_we_l,
    output logic        vblank_irq,
    output logic [7:0]  drop_count,
    output logic [4:0]  fifo_level
);

    localparam int          LW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] MOB_LAST = MOB_BASE + 16'd63;

    state_t             state_q, state_d;
    logic               vblank_d_q;
    logic               vblank_rise;
    logic [7:0]         drop_count_q;
    logic [9:0]         pf_addr_q;
    logic [7:0]         pf_data_q;
    logic               pf_we_l_q;
    logic [5:0]         mob_addr_q;
    logic [7:0]         mob_data_q;
    logic               mob_we_l_q;

    logic               in_pf, in_mob, handshake, push, drop, pop;
    logic [15:0]        off;
    logic [5:0]         unused_off_hi;
    wq_entry_t          new_entry, head;
    logic [ENTRY_W-1:0] fifo_dout;
    logic               fifo_full, fifo_empty;
    logic [LW-1:0]      fifo_lvl;

    // Address decode: one subtract serves both windows since MOB offsets fit in 6 bits.
    assign in_pf     = (wr_addr >= PF_BASE) && (wr_addr < MOB_BASE);
    assign in_mob    = (wr_addr >= MOB_BASE) && (wr_addr <= MOB_LAST);
    assign off       = wr_addr - (in_mob ? MOB_BASE : PF_BASE);
    assign unused_off_hi = off[15:10];
    assign handshake = wr_valid & wr_ready;
    assign push      = handshake & (in_pf | in_mob);
    assign drop      = handshake & ~(in_pf | in_mob);

    always_comb begin
        new_entry        = '0;
        new_entry.target = in_mob ? TGT_MOB : TGT_PF;
        new_entry.offset = off[9:0];
        new_entry.data   = wr_data;
    end

    assign head = wq_entry_t'(fifo_dout);
    assign pop  = (state_q == ST_DRAIN) & vblank & ~fifo_empty;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_l   (rst_l),
        .push_i  (push),
        .din_i   (new_entry),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_lvl)
    );

    assign wr_ready   = ~fifo_full;
    assign fifo_level = 5'(fifo_lvl);

    assign vblank_rise = vblank & ~vblank_d_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (vblank_rise) state_d = ST_GUARD;
            ST_GUARD: state_d = vblank ? ST_DRAIN : ST_IDLE;
            ST_DRAIN: if (!vblank) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // vblank_d resets high so a blanking interval in progress at release is ignored.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q      <= ST_IDLE;
            vblank_d_q   <= 1'b1;
            drop_count_q <= '0;
        end else begin
            state_q    <= state_d;
            vblank_d_q <= vblank;
            if (drop && drop_count_q != 8'hFF) drop_count_q <= drop_count_q + 8'd1;
        end
    end

    // Write ports: strobe for one cycle after a pop, addr/data hold otherwise.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            pf_addr_q  <= '0;
            pf_data_q  <= '0;
            pf_we_l_q  <= 1'b1;
            mob_addr_q <= '0;
            mob_data_q <= '0;
            mob_we_l_q <= 1'b1;
        end else begin
            pf_we_l_q  <= 1'b1;
            mob_we_l_q <= 1'b1;
            if (pop) begin
                if (head.target == TGT_MOB) begin
                    mob_addr_q <= head.offset[5:0];
                    mob_data_q <= head.data;
                    mob_we_l_q <= 1'b0;
                end else begin
                    pf_addr_q  <= head.offset;
                    pf_data_q  <= head.data;
                    pf_we_l_q  <= 1'b0;
                end
            end
        end
    end

    assign pf_addr    = pf_addr_q;
    assign pf_data    = pf_data_q;
    assign pf_we_l    = pf_we_l_q;
    assign mob_addr   = mob_addr_q;
    assign mob_data   = mob_data_q;
    assign mob_we_l   = mob_we_l_q;
    assign vblank_irq = (state_q == ST_GUARD);
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_vram_write_queue.sv
// Scoreboard bench: expected RAM writes are queued at push time and matched
// against observed write strobes.
module tb_vram_write_queue;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        wr_valid;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        vblank;
    logic [9:0]  pf_addr;
    logic [7:0]  pf_data;
    logic        pf_we_l;
    logic [5:0]  mob_addr;
    logic [7:0]  mob_data;
    logic        mob_we_l;
    logic        vblank_irq;
    logic [7:0]  drop_count;
    logic [4:0]  fifo_level;

    int          checks = 0;
    int          failures = 0;
    int          strobe_cnt = 0;
    int          drop_exp = 0;
    logic [18:0] sb[$];   // {target(1=MOB), offset[9:0], data[7:0]}

    always #5 clk = ~clk;

    vram_write_queue #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .vblank     (vblank),
        .pf_addr    (pf_addr),
        .pf_data    (pf_data),
        .pf_we_l    (pf_we_l),
        .mob_addr   (mob_addr),
        .mob_data   (mob_data),
        .mob_we_l   (mob_we_l),
        .vblank_irq (vblank_irq),
        .drop_count (drop_count),
        .fifo_level (fifo_level)
    );

    // Strobe monitor: every write strobe must match the oldest expected entry.
    initial begin
        forever begin
            logic [18:0] got, exp;
            @(negedge clk);
            if (!pf_we_l && !mob_we_l) begin
                checks++; failures++;
                $display("FAIL dual_strobe pf_we_l=%b mob_we_l=%b required one high", pf_we_l, mob_we_l);
            end else if (!pf_we_l || !mob_we_l) begin
                strobe_cnt++;
                checks++;
                got = !pf_we_l ? {1'b0, pf_addr, pf_data} : {1'b1, 4'b0, mob_addr, mob_data};
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_strobe got=%h with nothing queued", got);
                end else begin
                    exp = sb.pop_front();
                    if (got !== exp) begin
                        failures++;
                        $display("FAIL strobe_order got=%h exp=%h", got, exp);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one write for one cycle; the model decides acceptance from its own occupancy.
    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        logic hs;
        hs = (sb.size() < DEPTH);
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_valid = 1'b0;
        if (hs) begin
            if (a >= 16'h0400 && a < 16'h07C0)       sb.push_back({1'b0, 10'(a - 16'h0400), d});
            else if (a >= 16'h07C0 && a <= 16'h07FF) sb.push_back({1'b1, 10'(a - 16'h07C0), d});
            else if (drop_exp < 255)                 drop_exp++;
        end
    endtask

    task automatic run_vblank(input int n);
        vblank = 1'b1;
        repeat (n) tick();
        vblank = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst_l = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; vblank = 1'b0;
        repeat (3) tick();
        checks++; if ({pf_we_l, mob_we_l} !== 2'b11) begin failures++; $display("FAIL reset_we got=%b exp=11", {pf_we_l, mob_we_l}); end
        checks++; if ({pf_addr, pf_data, mob_addr, mob_data} !== 32'h0) begin failures++; $display("FAIL reset_addr_data got=%h exp=0", {pf_addr, pf_data, mob_addr, mob_data}); end
        checks++; if ({vblank_irq, drop_count, fifo_level} !== 14'h0) begin failures++; $display("FAIL reset_irq_drop_level got=%h exp=0", {vblank_irq, drop_count, fifo_level}); end
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", wr_ready); end
        rst_l = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_basic();
        int s0;
        wr(16'h0405, 8'hAA);
        wr(16'h07C3, 8'h55);
        checks++; if (fifo_level !== 5'd2) begin failures++; $display("FAIL basic_level got=%0d exp=2", fifo_level); end
        s0 = strobe_cnt;
        vblank = 1'b1;
        tick();
        checks++; if (vblank_irq !== 1'b1) begin failures++; $display("FAIL basic_irq_guard got=%b exp=1", vblank_irq); end
        tick();
        checks++; if (vblank_irq !== 1'b0) begin failures++; $display("FAIL basic_irq_pulse got=%b exp=0", vblank_irq); end
        repeat (6) tick();
        vblank = 1'b0;
        repeat (3) tick();
        checks++; if (strobe_cnt - s0 !== 2) begin failures++; $display("FAIL basic_strobes got=%0d exp=2", strobe_cnt - s0); end
        checks++; if (fifo_level !== 5'd0) begin failures++; $display("FAIL basic_drained got=%0d exp=0", fifo_level); end
        checks++; if ({pf_addr, pf_data} !== {10'd5, 8'hAA}) begin failures++; $display("FAIL basic_pf_hold got=%h/%h exp=005/aa", pf_addr, pf_data); end
        checks++; if ({mob_addr, mob_data} !== {6'd3, 8'h55}) begin failures++; $display("FAIL basic_mob_hold got=%h/%h exp=03/55", mob_addr, mob_data); end
    endtask

    task automatic test_full();
        int s0;
        for (int i = 0; i < DEPTH; i++)
            wr((i % 2 == 0) ? 16'(16'h0410 + i) : 16'(16'h07C0 + i), 8'(8'h10 + i));
        checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", wr_ready); end
        checks++; if (fifo_level !== 5'd8) begin failures++; $display("FAIL full_level got=%0d exp=8", fifo_level); end
        wr(16'h0500, 8'hEE);
        checks++; if (fifo_level !== 5'd8) begin failures++; $display("FAIL full_ignored got=%0d exp=8", fifo_level); end
        checks++; if (drop_count !== 8'(drop_exp)) begin failures++; $display("FAIL full_no_drop got=%0d exp=%0d", drop_count, drop_exp); end
        s0 = strobe_cnt;
        run_vblank(14);
        checks++; if (strobe_cnt - s0 !== 8) begin failures++; $display("FAIL full_strobes got=%0d exp=8", strobe_cnt - s0); end
        checks++; if (fifo_level !== 5'd0) begin failures++; $display("FAIL full_drained got=%0d exp=0", fifo_level); end
    endtask

    task automatic test_drop();
        wr(16'h0000, 8'h01);
        wr(16'h0800, 8'h02);
        wr(16'hFFFF, 8'h03);
        checks++; if (drop_count !== 8'(drop_exp) || drop_exp != 3) begin failures++; $display("FAIL drop_three got=%0d exp=3", drop_count); end
        checks++; if (fifo_level !== 5'd0) begin failures++; $display("FAIL drop_level got=%0d exp=0", fifo_level); end
        for (int i = 0; i < 257; i++) wr(16'(16'h0800 + i), 8'(i));
        checks++; if (drop_count !== 8'd255) begin failures++; $display("FAIL drop_saturate got=%0d exp=255", drop_count); end
    endtask

    task automatic test_partial_vblank();
        int s0;
        for (int i = 0; i < 6; i++) wr(16'(16'h0600 + i), 8'(8'h60 + i));
        s0 = strobe_cnt;
        // Blanking covers the edge cycle, GUARD, and three DRAIN cycles.
        vblank = 1'b1;
        repeat (5) tick();
        vblank = 1'b0;
        repeat (4) tick();
        checks++; if (strobe_cnt - s0 !== 3) begin failures++; $display("FAIL partial_strobes got=%0d exp=3", strobe_cnt - s0); end
        checks++; if (fifo_level !== 5'd3) begin failures++; $display("FAIL partial_remain got=%0d exp=3", fifo_level); end
        run_vblank(10);
        checks++; if (strobe_cnt - s0 !== 6) begin failures++; $display("FAIL partial_next_vblank got=%0d exp=6", strobe_cnt - s0); end
        checks++; if (fifo_level !== 5'd0) begin failures++; $display("FAIL partial_drained got=%0d exp=0", fifo_level); end
    endtask

    task automatic test_push_during_drain();
        int s0;
        for (int i = 0; i < 3; i++) wr(16'(16'h0700 + i), 8'(8'h70 + i));
        s0 = strobe_cnt;
        vblank = 1'b1;
        tick();
        tick();
        wr(16'h07D0, 8'hC0);
        checks++; if (fifo_level !== 5'd3) begin failures++; $display("FAIL drain_push_level1 got=%0d exp=3", fifo_level); end
        wr(16'h07D1, 8'hC1);
        checks++; if (fifo_level !== 5'd3) begin failures++; $display("FAIL drain_push_level2 got=%0d exp=3", fifo_level); end
        repeat (8) tick();
        vblank = 1'b0;
        repeat (3) tick();
        checks++; if (strobe_cnt - s0 !== 5) begin failures++; $display("FAIL drain_push_strobes got=%0d exp=5", strobe_cnt - s0); end
        checks++; if (fifo_level !== 5'd0) begin failures++; $display("FAIL drain_push_empty got=%0d exp=0", fifo_level); end
    endtask

    task automatic test_reset_mid_drain();
        int s1;
        for (int i = 0; i < 5; i++) wr(16'(16'h07E0 + i), 8'(8'h90 + i));
        vblank = 1'b1;
        repeat (4) tick();
        rst_l = 1'b0;
        #1;
        checks++; if ({pf_we_l, mob_we_l} !== 2'b11) begin failures++; $display("FAIL rst_mid_we got=%b exp=11", {pf_we_l, mob_we_l}); end
        checks++; if (fifo_level !== 5'd0) begin failures++; $display("FAIL rst_mid_level got=%0d exp=0", fifo_level); end
        checks++; if (drop_count !== 8'd0) begin failures++; $display("FAIL rst_mid_drop got=%0d exp=0", drop_count); end
        drop_exp = 0;
        sb.delete();
        s1 = strobe_cnt;
        repeat (3) tick();
        rst_l = 1'b1;
        repeat (6) tick();
        checks++; if (strobe_cnt !== s1) begin failures++; $display("FAIL rst_release_strobe got=%0d exp=%0d", strobe_cnt, s1); end
        vblank = 1'b0;
        repeat (2) tick();
        wr(16'h0401, 8'h11);
        run_vblank(6);
        checks++; if (strobe_cnt - s1 !== 1) begin failures++; $display("FAIL rst_next_vblank got=%0d exp=1", strobe_cnt - s1); end
    endtask

    task automatic test_boundary();
        int s0;
        wr(16'h0400, 8'h01);
        wr(16'h07BF, 8'h02);
        wr(16'h07C0, 8'h03);
        wr(16'h07FF, 8'h04);
        wr(16'h03FF, 8'h05);
        wr(16'h0800, 8'h06);
        checks++; if (drop_count !== 8'(drop_exp) || drop_exp != 2) begin failures++; $display("FAIL bound_drops got=%0d exp=2", drop_count); end
        checks++; if (fifo_level !== 5'd4) begin failures++; $display("FAIL bound_level got=%0d exp=4", fifo_level); end
        s0 = strobe_cnt;
        run_vblank(10);
        checks++; if (strobe_cnt - s0 !== 4) begin failures++; $display("FAIL bound_strobes got=%0d exp=4", strobe_cnt - s0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_drop();
        test_partial_vblank();
        test_push_during_drain();
        test_reset_mid_drain();
        test_boundary();
        repeat (3) tick();
        checks++; if (sb.size() !== 0) begin failures++; $display("FAIL scoreboard_left got=%0d exp=0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
